// File: rtl/puf_rd_ctrl.sv
// PUF read controller: starts a PUF run, waits for completion or timeout, then
// streams the response words through a 2-entry output FIFO with valid/ready.
module puf_rd_ctrl #(
   parameter int unsigned Bpc = 4,
   parameter int unsigned Dbw = 64,
   parameter int unsigned Mnc = 4096,
   parameter int unsigned TMO = 65535,
   localparam int unsigned AW = $clog2(Mnc * Bpc / Dbw - 1),
   localparam int unsigned CW = $clog2(Mnc) + 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [CW-1:0]  n_cmps,
   output logic           puf_str,
   output logic [CW-1:0]  puf_n_cmps,
   input  logic           puf_end,
   output logic [AW-1:0]  puf_addr,
   input  logic [Dbw-1:0] puf_out,
   output logic [Dbw-1:0] dout,
   output logic           dout_valid,
   input  logic           dout_ready,
   output logic           dout_last,
   output logic           busy,
   output logic           done,
   output logic           err
);

   localparam int unsigned TW = $clog2(TMO + 1);
   localparam int unsigned PW = CW + $clog2(Bpc) + 1;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_READ, S_DRAIN, S_DONE, S_ERR} state_t;

   state_t         state, state_n;
   logic           n_ok, pop, issue, at_last, fifo_empty;
   logic [1:0]     occ;
   logic [AW-1:0]  last_addr;
   logic [TW-1:0]  tmo_cnt;
   logic           pend, pend_last;
   logic [Dbw-1:0] t_data;
   logic           t_last, t_valid;
   logic           str_n, busy_n, done_n, err_n;

   assign n_ok       = (n_cmps != '0) && (n_cmps <= CW'(Mnc));
   assign pop        = dout_valid & dout_ready;
   // Occupancy as it will stand after this cycle's pop, so a full-rate stream never bubbles.
   assign occ        = 2'(dout_valid) + 2'(t_valid) + 2'(pend) - 2'(pop);
   assign issue      = (state == S_READ) && (occ < 2'd2);
   assign at_last    = (puf_addr == last_addr);
   assign fifo_empty = !dout_valid && !t_valid && !pend;

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start) state_n = n_ok ? S_RUN : S_ERR;
         S_RUN: begin
            if (puf_end)                         state_n = S_READ;
            else if (tmo_cnt == TW'(TMO - 1))    state_n = S_ERR;
         end
         S_READ:  if (issue && at_last) state_n = S_DRAIN;
         S_DRAIN: if (fifo_empty)       state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         S_ERR:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      str_n  = (state_n == S_RUN);
      busy_n = (state_n != S_IDLE);
      done_n = (state_n == S_DONE);
      err_n  = err;
      if (state_n == S_ERR)                err_n = 1'b1;
      else if (state == S_IDLE && start)   err_n = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         puf_str <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         puf_str <= str_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
      end
   end

   // Command capture, timeout counter and read-address sequencing.
   always_ff @(posedge clock) begin
      if (reset) begin
         puf_n_cmps <= '0;
         last_addr  <= '0;
         puf_addr   <= '0;
         tmo_cnt    <= '0;
         pend       <= 1'b0;
         pend_last  <= 1'b0;
      end else begin
         if (state == S_IDLE && start && n_ok) begin
            puf_n_cmps <= n_cmps;
            last_addr  <= AW'((PW'(n_cmps) * PW'(Bpc) + PW'(Dbw - 1)) / PW'(Dbw) - PW'(1));
            puf_addr   <= '0;
         end else if (issue && !at_last) begin
            puf_addr <= puf_addr + AW'(1);
         end
         tmo_cnt   <= (state == S_RUN) ? tmo_cnt + TW'(1) : '0;
         pend      <= issue;
         pend_last <= issue && at_last;
      end
   end

   // Output FIFO: head entry drives dout directly, tail entry absorbs a stalled push.
   always_ff @(posedge clock) begin
      if (reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         t_data     <= '0;
         t_last     <= 1'b0;
         t_valid    <= 1'b0;
      end else if (pop) begin
         if (t_valid) begin
            dout      <= t_data;
            dout_last <= t_last;
            if (pend) begin
               t_data <= puf_out;
               t_last <= pend_last;
            end else begin
               t_valid <= 1'b0;
            end
         end else if (pend) begin
            dout      <= puf_out;
            dout_last <= pend_last;
         end else begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
         end
      end else if (pend) begin
         if (!dout_valid) begin
            dout       <= puf_out;
            dout_last  <= pend_last;
            dout_valid <= 1'b1;
         end else begin
            t_data  <= puf_out;
            t_last  <= pend_last;
            t_valid <= 1'b1;
         end
      end
   end

endmodule
